// File: rtl/pcq_fu_clk_seq_if.sv
// rtl/pcq_fu_clk_seq_if.sv - request/status and FU clock-control bundle for pcq_fu_clk_seq
// master drives requests and observes controls; slave is the sequencer side.
interface pcq_fu_clk_seq_if;
  logic       ct_start_req;
  logic       ct_stop_req;
  logic       ct_scan_req;
  logic       ct_fce_req;
  logic       ct_slp_keep;
  logic       ct_busy;
  logic       ct_running;
  logic       ct_done;
  logic       ct_err;
  logic       pc_fu_gptr_sl_thold_3;
  logic       pc_fu_cfg_sl_thold_3;
  logic       pc_fu_repr_sl_thold_3;
  logic       pc_fu_time_sl_thold_3;
  logic       pc_fu_abst_sl_thold_3;
  logic       pc_fu_ary_nsl_thold_3;
  logic [0:1] pc_fu_func_sl_thold_3;
  logic [0:1] pc_fu_func_slp_sl_thold_3;
  logic [0:1] pc_fu_sg_3;
  logic       pc_fu_fce_3;

  modport master (
    output ct_start_req, ct_stop_req, ct_scan_req, ct_fce_req, ct_slp_keep,
    input  ct_busy, ct_running, ct_done, ct_err,
    input  pc_fu_gptr_sl_thold_3, pc_fu_cfg_sl_thold_3, pc_fu_repr_sl_thold_3,
    input  pc_fu_time_sl_thold_3, pc_fu_abst_sl_thold_3, pc_fu_ary_nsl_thold_3,
    input  pc_fu_func_sl_thold_3, pc_fu_func_slp_sl_thold_3, pc_fu_sg_3, pc_fu_fce_3
  );

  modport slave (
    input  ct_start_req, ct_stop_req, ct_scan_req, ct_fce_req, ct_slp_keep,
    output ct_busy, ct_running, ct_done, ct_err,
    output pc_fu_gptr_sl_thold_3, pc_fu_cfg_sl_thold_3, pc_fu_repr_sl_thold_3,
    output pc_fu_time_sl_thold_3, pc_fu_abst_sl_thold_3, pc_fu_ary_nsl_thold_3,
    output pc_fu_func_sl_thold_3, pc_fu_func_slp_sl_thold_3, pc_fu_sg_3, pc_fu_fce_3
  );
endinterface

// File: rtl/pcq_fu_clk_seq.sv
// rtl/pcq_fu_clk_seq.sv - staged FU clock ramp up/down sequencer with sg/fce gating
// Optional feature macro: FU_SEQ_SLP_KEEP_EN (honour ct_slp_keep at stop accept).
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif
module pcq_fu_clk_seq #(
  parameter int GAP_CYCLES = 4
) (
  input  logic [0:`NCLK_WIDTH-1] nclk,
  pcq_fu_clk_seq_if.slave        bus
);
  typedef enum logic [1:0] {STOPPED, RAMP_UP, RUNNING, RAMP_DN} state_e;
  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

  logic       clk, rst;
  state_e     state_q;
  logic [1:0] stage_q;
  logic [3:0] gap_q;
  logic [3:0] hold_q;
  logic       slp_hold_q;
  logic       busy_q, running_q, done_q, err_q;
  logic       scan_prev_q, sg_q, fce_q;
  logic       start_req, stop_req, keep_in, scan_rise;
  logic       sg_d, fce_d, err_d;

  assign clk       = nclk[0];
  assign rst       = nclk[1];
  assign start_req = bus.ct_start_req;
  assign stop_req  = bus.ct_stop_req;

`ifdef FU_SEQ_SLP_KEEP_EN
  assign keep_in = bus.ct_slp_keep;
`else
  logic unused_slp_keep;
  assign unused_slp_keep = bus.ct_slp_keep;
  assign keep_in = 1'b0;
`endif

  // sg may only rise while stopped but drops as soon as the request drops
  assign scan_rise = bus.ct_scan_req & ~scan_prev_q;
  assign sg_d      = bus.ct_scan_req & (sg_q | (state_q == STOPPED));
  assign fce_d     = bus.ct_fce_req & sg_d;
  assign err_d     = (busy_q & (start_req | stop_req))
                   | ((state_q == STOPPED) & (stop_req | (start_req & sg_q)))
                   | ((state_q == RUNNING) & start_req & ~stop_req)
                   | ((state_q != STOPPED) & scan_rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STOPPED;
      stage_q     <= 2'd0;
      gap_q       <= 4'd0;
      hold_q      <= 4'hf;
      slp_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      scan_prev_q <= 1'b0;
      sg_q        <= 1'b0;
      fce_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= err_d;
      scan_prev_q <= bus.ct_scan_req;
      sg_q        <= sg_d;
      fce_q       <= fce_d;
      case (state_q)
        STOPPED: begin
          if (start_req && !stop_req && !sg_q) begin
            state_q   <= RAMP_UP;
            busy_q    <= 1'b1;
            stage_q   <= 2'd0;
            gap_q     <= GAP_LD;
            hold_q[0] <= 1'b0;
          end
        end
        RAMP_UP: begin
          if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
          end else if (stage_q == 2'd3) begin
            state_q   <= RUNNING;
            busy_q    <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            stage_q                  <= stage_q + 2'd1;
            hold_q[stage_q + 2'd1]   <= 1'b0;
            gap_q                    <= GAP_LD;
            if (stage_q == 2'd2) slp_hold_q <= 1'b0;
          end
        end
        RUNNING: begin
          if (stop_req) begin
            state_q    <= RAMP_DN;
            busy_q     <= 1'b1;
            running_q  <= 1'b0;
            stage_q    <= 2'd3;
            gap_q      <= GAP_LD;
            hold_q[3]  <= 1'b1;
            // a kept sleep domain simply never gets its hold re-asserted
            slp_hold_q <= ~keep_in;
          end
        end
        RAMP_DN: begin
          if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
          end else if (stage_q == 2'd0) begin
            state_q <= STOPPED;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            stage_q                <= stage_q - 2'd1;
            hold_q[stage_q - 2'd1] <= 1'b1;
            gap_q                  <= GAP_LD;
          end
        end
        default: state_q <= STOPPED;
      endcase
    end
  end

  assign bus.ct_busy                   = busy_q;
  assign bus.ct_running                = running_q;
  assign bus.ct_done                   = done_q;
  assign bus.ct_err                    = err_q;
  assign bus.pc_fu_gptr_sl_thold_3     = hold_q[0];
  assign bus.pc_fu_cfg_sl_thold_3      = hold_q[1];
  assign bus.pc_fu_repr_sl_thold_3     = hold_q[1];
  assign bus.pc_fu_time_sl_thold_3     = hold_q[2];
  assign bus.pc_fu_abst_sl_thold_3     = hold_q[2];
  assign bus.pc_fu_ary_nsl_thold_3     = hold_q[2];
  assign bus.pc_fu_func_sl_thold_3     = {2{hold_q[3]}};
  assign bus.pc_fu_func_slp_sl_thold_3 = {2{slp_hold_q}};
  assign bus.pc_fu_sg_3                = {2{sg_q}};
  assign bus.pc_fu_fce_3               = fce_q;
endmodule

// File: tb/tb_pcq_fu_clk_seq.sv
// tb/tb_pcq_fu_clk_seq.sv - self-checking bench for pcq_fu_clk_seq
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif
module tb_pcq_fu_clk_seq;
  localparam int G = 4;
  localparam int K = 4 * G;
`ifdef FU_SEQ_SLP_KEEP_EN
  localparam logic KEEP_EN = 1'b1;
`else
  localparam logic KEEP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        scan;
    logic        fce;
    logic        keep;
    logic [16:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:`NCLK_WIDTH-1] nclk;
  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] sbq[$];
  string       nmq[$];
  vec_t        vecs[10];

  pcq_fu_clk_seq_if bus();
  pcq_fu_clk_seq #(.GAP_CYCLES(G)) dut (.nclk(nclk), .bus(bus));

  always #5 clk = ~clk;
  always_comb begin
    nclk    = '0;
    nclk[0] = clk;
    nclk[1] = rst;
  end

  // {busy, running, done, err, gptr, cfg, repr, time, abst, ary, func[2], slp[2], sg[2], fce}
  function automatic logic [16:0] mk(input logic b, r, d, e, h0, h1, h2, hf, hs, sg, fc);
    return {b, r, d, e, h0, h1, h1, h2, h2, h2, hf, hf, hs, hs, sg, sg, fc};
  endfunction

  function automatic logic [16:0] st(input logic hs);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, hs, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] obs();
    return {bus.ct_busy, bus.ct_running, bus.ct_done, bus.ct_err,
            bus.pc_fu_gptr_sl_thold_3, bus.pc_fu_cfg_sl_thold_3, bus.pc_fu_repr_sl_thold_3,
            bus.pc_fu_time_sl_thold_3, bus.pc_fu_abst_sl_thold_3, bus.pc_fu_ary_nsl_thold_3,
            bus.pc_fu_func_sl_thold_3, bus.pc_fu_func_slp_sl_thold_3, bus.pc_fu_sg_3,
            bus.pc_fu_fce_3};
  endfunction

  task automatic setin(input logic s, p, c, f, k);
    bus.ct_start_req = s;
    bus.ct_stop_req  = p;
    bus.ct_scan_req  = c;
    bus.ct_fce_req   = f;
    bus.ct_slp_keep  = k;
  endtask

  task automatic step(input string nm, input logic [16:0] e);
    logic [16:0] got, want;
    string       wn;
    sbq.push_back(e);
    nmq.push_back(nm);
    @(posedge clk);
    #1;
    got  = obs();
    want = sbq.pop_front();
    wn   = nmq.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", wn, got, want);
    end
  endtask

  task automatic ramp_up(input logic slp0, input int inj, input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      setin((k == 0) || (k == inj), 1'b0, 1'b0, 1'b0, 1'b0);
      step($sformatf("up k=%0d", k),
           mk(k < K, k >= K, k == K, k == inj, 1'b0, k < G, k < 2*G, k < 3*G,
              slp0 ? 1'b0 : (k < 3*G), 1'b0, 1'b0));
    end
    setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ramp_dn(input logic keep, input int inj);
    logic hs;
    hs = ~(keep & KEEP_EN);
    for (int k = 0; k <= K; k++) begin
      setin(1'b0, (k == 0) || (k == inj), 1'b0, 1'b0, keep);
      step($sformatf("dn k=%0d keep=%0b", k, keep),
           mk(k < K, 1'b0, k == K, k == inj, k >= 3*G, k >= 2*G, k >= G, 1'b1, hs, 1'b0, 1'b0));
    end
    setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st(1'b1)};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0)};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0)};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1)};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1)};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st(1'b1)};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0)};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st(1'b1)};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st(1'b1)};

    setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("reset0", st(1'b1));
    step("reset1", st(1'b1));
    rst = 1'b0;

    foreach (vecs[i]) begin
      setin(vecs[i].start, vecs[i].stop, vecs[i].scan, vecs[i].fce, vecs[i].keep);
      step($sformatf("vec%0d", i), vecs[i].exp);
    end
    setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    ramp_up(1'b0, 2, K);
    step("run idle", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    setin(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("scan rise in run", mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step("scan held in run", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start in run", mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    ramp_dn(1'b0, 5);
    step("stopped idle", st(1'b1));

    ramp_up(1'b0, -1, K);
    ramp_dn(1'b1, -1);
    step("stopped after keep", st(~KEEP_EN));
    ramp_up(KEEP_EN, -1, K);
    ramp_dn(1'b0, -1);
    step("stopped after nokeep", st(1'b1));

    ramp_up(1'b0, -1, 2*G - 1);
    rst = 1'b1;
    step("reset at S2", st(1'b1));
    rst = 1'b0;
    step("after mid reset", st(1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
